// File: rtl/atari_bus_pkg.sv
// -----------------------------------------------------------------------------
// atari_bus_pkg
// Shared definitions for the Atari cartridge-bus capture logic:
//   - cctl_state_e : capture FSM states (IDLE, HIGH, QUAL, COMMIT)
//   - HCNT_W       : width of the PHI2-high cycle counter
//   - ADDR_W/DATA_W: widths of the captured bus fields
//   - BUS_W        : width of the packed synchronized bus vector
//   - hcnt_inc()   : saturating increment for the PHI2-high counter
// -----------------------------------------------------------------------------
package atari_bus_pkg;

   localparam int HCNT_W = 4;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   // {phi2, rw, cctl_n, addr[7:0], data[7:0]}
   localparam int BUS_W  = 3 + ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIGH   = 2'd1,
      QUAL   = 2'd2,
      COMMIT = 2'd3
   } cctl_state_e;

   // Counter sticks at all-ones so a long PHI2-high phase never wraps.
   function automatic logic [HCNT_W-1:0] hcnt_inc(input logic [HCNT_W-1:0] cnt);
      if (&cnt) begin
         return cnt;
      end
      return cnt + 1'b1;
   endfunction

endpackage

// File: rtl/bus_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
// Multi-bit, STAGES-deep flop-chain synchronizer with asynchronous active-low
// reset. Every bit sees the same depth, so bits that change together at the
// input leave the chain together.
// Ports:
//   clk      in  1      destination clock
//   reset_n  in  1      asynchronous active-low reset (chain clears to 0)
//   d_i      in  WIDTH  asynchronous input vector
//   q_o      out WIDTH  synchronized vector (last stage of the chain)
// -----------------------------------------------------------------------------
module bus_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] chain_q [STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         chain_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/atari_cctl_write_capture.sv
// -----------------------------------------------------------------------------
// atari_cctl_write_capture
// Watches the asynchronous Atari cartridge bus, detects CPU writes to the
// $D5xx (CCTL) window and presents the last written byte/address statically
// to the host, together with a commit strobe and pending/overrun flags.
//
// Optional feature: define D500_ADDR_FILTER_EN to commit only writes whose
// low address equals FILTER_ADDR (d500_addr then always reports FILTER_ADDR).
//
// Ports:
//   clk        in  1  system clock
//   reset_n    in  1  asynchronous active-low reset
//   phi2       in  1  Atari PHI2 (async)
//   rw         in  1  Atari R/W, 1 = read (async)
//   cctl_n     in  1  Atari CCTL, active-low $D5xx select (async)
//   bus_addr   in  8  Atari A7..A0 (async)
//   bus_data   in  8  Atari D7..D0 (async)
//   ack        in  1  host clears pending/overrun (level)
//   d500_byte  out 8  last captured write data
//   d500_addr  out 8  low address of the last captured write
//   strobe     out 1  one-cycle pulse, coincident with new d500_byte/addr
//   pending    out 1  capture not yet acknowledged
//   overrun    out 1  an unacknowledged capture was overwritten
// -----------------------------------------------------------------------------
module atari_cctl_write_capture
   import atari_bus_pkg::*;
#(
   parameter int          SYNC_STAGES     = 2,
   parameter int          MIN_HIGH_CYCLES = 4,
   parameter logic [7:0]  FILTER_ADDR     = 8'h00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              phi2,
   input  logic              rw,
   input  logic              cctl_n,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_data,
   input  logic              ack,
   output logic [DATA_W-1:0] d500_byte,
   output logic [ADDR_W-1:0] d500_addr,
   output logic              strobe,
   output logic              pending,
   output logic              overrun
);

   localparam logic [HCNT_W-1:0] MIN_HC = HCNT_W'(MIN_HIGH_CYCLES);

   // ---------------------------------------------------------------------------
   // Synchronized bus
   // ---------------------------------------------------------------------------
   logic [BUS_W-1:0]  bus_raw;
   logic [BUS_W-1:0]  bus_s;
   logic              s_phi2;
   logic              s_rw;
   logic              s_cctl_n;
   logic [ADDR_W-1:0] s_bus_addr;
   logic [DATA_W-1:0] s_bus_data;

   assign bus_raw = {phi2, rw, cctl_n, bus_addr, bus_data};

   bus_sync #(
      .WIDTH  (BUS_W),
      .STAGES (SYNC_STAGES)
   ) u_bus_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (bus_raw),
      .q_o     (bus_s)
   );

   assign {s_phi2, s_rw, s_cctl_n, s_bus_addr, s_bus_data} = bus_s;

   // ---------------------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------------------
   cctl_state_e       state_q,     state_d;
   logic [HCNT_W-1:0] hcnt_q,      hcnt_d;
   logic [DATA_W-1:0] s_data_q,    s_data_d;
   logic [ADDR_W-1:0] s_addr_q,    s_addr_d;
   logic [DATA_W-1:0] d500_byte_q, d500_byte_d;
   logic [ADDR_W-1:0] d500_addr_q, d500_addr_d;
   logic              pending_q,   pending_d;
   logic              overrun_q,   overrun_d;
   logic              armed_q,     armed_d;
   logic [SYNC_STAGES-1:0] prime_q, prime_d;

   logic primed;
   logic addr_ok;
   logic capture;
   logic in_commit;

   // The synchronizer outputs 0 for SYNC_STAGES cycles after reset regardless
   // of the bus. prime_q walks a 1 through the same depth so we know when
   // s_phi2 reflects the real pin again; only a genuine low PHI2 after that
   // point arms the FSM, which discards any bus cycle in flight at reset.
   assign prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
   assign primed  = prime_q[SYNC_STAGES-1];
   assign armed_d = armed_q | (primed & ~s_phi2);

`ifdef D500_ADDR_FILTER_EN
   assign addr_ok     = (s_addr_q == FILTER_ADDR);
   assign d500_addr_d = capture ? FILTER_ADDR : d500_addr_q;
`else
   logic unused_filter_addr;
   assign unused_filter_addr = ^FILTER_ADDR;
   assign addr_ok            = 1'b1;
   assign d500_addr_d        = capture ? s_addr_q : d500_addr_q;
`endif

   // Shadows follow the bus only during PHI2 high, so once PHI2 drops they
   // hold the data/address from the final high cycle of the bus cycle.
   assign s_data_d = s_phi2 ? s_bus_data : s_data_q;
   assign s_addr_d = s_phi2 ? s_bus_addr : s_addr_q;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (armed_q && s_phi2) begin
               state_d = HIGH;
               hcnt_d  = HCNT_W'(1);
            end
         end
         HIGH: begin
            if (!s_phi2) begin
               // Either a glitch (too short) or a complete non-qualifying
               // cycle; neither commits.
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt_inc(hcnt_q);
               if ((hcnt_d >= MIN_HC) && !s_cctl_n && !s_rw && addr_ok) begin
                  state_d = QUAL;
               end
            end
         end
         QUAL: begin
            if (!s_phi2) begin
               // Output registers load on entry to COMMIT so the new value
               // and the strobe appear in the same cycle.
               state_d = COMMIT;
               capture = 1'b1;
            end else if (s_cctl_n || s_rw) begin
               state_d = HIGH;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign d500_byte_d = capture ? s_data_q : d500_byte_q;

   // Flags react to the strobe cycle itself, so an ack raised while the
   // strobe is high is seen together with the commit.
   assign in_commit = (state_q == COMMIT);
   assign pending_d = in_commit | (pending_q & ~ack);
   assign overrun_d = (in_commit & pending_q & ~ack) | (overrun_q & ~ack);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         hcnt_q      <= '0;
         s_data_q    <= '0;
         s_addr_q    <= '0;
         d500_byte_q <= '0;
         d500_addr_q <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         armed_q     <= 1'b0;
         prime_q     <= '0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         s_data_q    <= s_data_d;
         s_addr_q    <= s_addr_d;
         d500_byte_q <= d500_byte_d;
         d500_addr_q <= d500_addr_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         armed_q     <= armed_d;
         prime_q     <= prime_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign d500_byte = d500_byte_q;
   assign d500_addr = d500_addr_q;
   assign strobe    = in_commit;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_atari_cctl_write_capture.sv
// -----------------------------------------------------------------------------
// tb_atari_cctl_write_capture
// Directed bench for atari_cctl_write_capture (SYNC_STAGES=2,
// MIN_HIGH_CYCLES=4, FILTER_ADDR=8'h00). Bus inputs change on the falling
// clock edge; outputs are sampled 1 ns after the rising edge.
// With D500_ADDR_FILTER_EN defined, the address-filter sequence runs instead
// of the default-build sequence.
// -----------------------------------------------------------------------------
module tb_atari_cctl_write_capture;
   import atari_bus_pkg::*;

   localparam int LOW_CYC = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       phi2;
   logic       rw;
   logic       cctl_n;
   logic [7:0] bus_addr;
   logic [7:0] bus_data;
   logic       ack;
   logic [7:0] d500_byte;
   logic [7:0] d500_addr;
   logic       strobe;
   logic       pending;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   atari_cctl_write_capture #(
      .SYNC_STAGES     (2),
      .MIN_HIGH_CYCLES (4),
      .FILTER_ADDR     (8'h00)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .phi2      (phi2),
      .rw        (rw),
      .cctl_n    (cctl_n),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .ack       (ack),
      .d500_byte (d500_byte),
      .d500_addr (d500_addr),
      .strobe    (strobe),
      .pending   (pending),
      .overrun   (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: PHI2 high for hi clk cycles, then low for LOW_CYC cycles.
   // Reports the number of strobes and the clk edge (counted from the PHI2
   // fall) at which the first strobe was seen. Optionally raises ack for
   // exactly the strobe cycle.
   task automatic bus_cycle(input logic rw_v, input logic cctl_v,
                            input logic [7:0] a, input logic [7:0] d,
                            input int hi, input bit ack_on_strobe,
                            output int nstb, output int lat);
      @(negedge clk);
      rw = rw_v; cctl_n = cctl_v; bus_addr = a; bus_data = d; phi2 = 1'b1;
      repeat (hi) @(negedge clk);
      phi2 = 1'b0;
      nstb = 0;
      lat  = 0;
      for (int k = 1; k <= LOW_CYC; k++) begin
         @(posedge clk);
         #1;
         if (strobe === 1'b1) begin
            nstb++;
            if (lat == 0) lat = k;
         end
         ack = ack_on_strobe && (strobe === 1'b1);
      end
      ack = 1'b0; rw = 1'b1; cctl_n = 1'b1;
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nstb;
      int lat;

      reset_n = 1'b0; phi2 = 1'b0; rw = 1'b1; cctl_n = 1'b1;
      bus_addr = 8'h00; bus_data = 8'h00; ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_byte",    d500_byte, 8'h00);
      chk("rst_addr",    d500_addr, 8'h00);
      chk("rst_strobe",  strobe,    1'b0);
      chk("rst_pending", pending,   1'b0);
      chk("rst_overrun", overrun,   1'b0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

`ifdef D500_ADDR_FILTER_EN
      bus_cycle(1'b0, 1'b0, 8'h01, 8'h11, 10, 1'b0, nstb, lat);
      chk("flt_nomatch_strobe",  nstb,      0);
      chk("flt_nomatch_byte",    d500_byte, 8'h00);
      chk("flt_nomatch_pending", pending,   1'b0);
      bus_cycle(1'b0, 1'b0, 8'h00, 8'h22, 10, 1'b0, nstb, lat);
      chk("flt_match_strobe",    nstb,      1);
      chk("flt_match_byte",      d500_byte, 8'h22);
      chk("flt_match_addr",      d500_addr, 8'h00);
      chk("flt_match_pending",   pending,   1'b1);
`else
      // Write $D512 <- A5
      bus_cycle(1'b0, 1'b0, 8'h12, 8'hA5, 10, 1'b0, nstb, lat);
      chk("w1_strobes", nstb,      1);
      chk("w1_latency", lat,       3);
      chk("w1_byte",    d500_byte, 8'hA5);
      chk("w1_addr",    d500_addr, 8'h12);
      chk("w1_pending", pending,   1'b1);
      chk("w1_overrun", overrun,   1'b0);
      chk("w1_strobe_low", strobe, 1'b0);

      // Read cycle, then a write outside CCTL
      bus_cycle(1'b1, 1'b0, 8'h12, 8'h3C, 10, 1'b0, nstb, lat);
      chk("rd_strobes", nstb,      0);
      chk("rd_byte",    d500_byte, 8'hA5);
      bus_cycle(1'b0, 1'b1, 8'h34, 8'h3C, 10, 1'b0, nstb, lat);
      chk("nocctl_strobes", nstb,      0);
      chk("nocctl_byte",    d500_byte, 8'hA5);
      chk("nocctl_addr",    d500_addr, 8'h12);

      // PHI2 glitch of 2 clk
      bus_cycle(1'b0, 1'b0, 8'h12, 8'hC3, 2, 1'b0, nstb, lat);
      chk("glitch_strobes", nstb,      0);
      chk("glitch_byte",    d500_byte, 8'hA5);
      chk("glitch_idle",    dut.state_q, IDLE);

      // Clear, then two writes without ack
      ack_pulse();
      chk("ack0_pending", pending, 1'b0);
      chk("ack0_overrun", overrun, 1'b0);
      bus_cycle(1'b0, 1'b0, 8'h20, 8'h01, 10, 1'b0, nstb, lat);
      chk("b2b1_pending", pending, 1'b1);
      chk("b2b1_overrun", overrun, 1'b0);
      bus_cycle(1'b0, 1'b0, 8'h21, 8'h02, 10, 1'b0, nstb, lat);
      chk("b2b2_byte",    d500_byte, 8'h02);
      chk("b2b2_addr",    d500_addr, 8'h21);
      chk("b2b2_pending", pending,   1'b1);
      chk("b2b2_overrun", overrun,   1'b1);
      ack_pulse();
      chk("ack1_pending", pending, 1'b0);
      chk("ack1_overrun", overrun, 1'b0);

      // ack coincident with the commit
      bus_cycle(1'b0, 1'b0, 8'h30, 8'h77, 10, 1'b1, nstb, lat);
      chk("ackc1_byte",    d500_byte, 8'h77);
      chk("ackc1_pending", pending,   1'b1);
      chk("ackc1_overrun", overrun,   1'b0);
      // Same with a capture already pending: ack suppresses the overrun
      bus_cycle(1'b0, 1'b0, 8'h31, 8'h78, 10, 1'b1, nstb, lat);
      chk("ackc2_byte",    d500_byte, 8'h78);
      chk("ackc2_pending", pending,   1'b1);
      chk("ackc2_overrun", overrun,   1'b0);

      // Reset in the middle of a qualified write of EE
      @(negedge clk);
      rw = 1'b0; cctl_n = 1'b0; bus_addr = 8'h34; bus_data = 8'hEE; phi2 = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid_in_qual", dut.state_q, QUAL);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_byte",    d500_byte, 8'h00);
      chk("mid_rst_addr",    d500_addr, 8'h00);
      chk("mid_rst_pending", pending,   1'b0);
      chk("mid_rst_strobe",  strobe,    1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("mid_held_idle", dut.state_q, IDLE);
      phi2 = 1'b0;
      nstb = 0;
      for (int k = 0; k < LOW_CYC; k++) begin
         @(posedge clk);
         #1;
         if (strobe === 1'b1) nstb++;
      end
      rw = 1'b1; cctl_n = 1'b1;
      chk("mid_no_commit", nstb,      0);
      chk("mid_byte",      d500_byte, 8'h00);
      chk("mid_pending",   pending,   1'b0);

      bus_cycle(1'b0, 1'b0, 8'h56, 8'h5A, 10, 1'b0, nstb, lat);
      chk("post_strobes", nstb,      1);
      chk("post_byte",    d500_byte, 8'h5A);
      chk("post_addr",    d500_addr, 8'h56);
      chk("post_pending", pending,   1'b1);
      chk("post_overrun", overrun,   1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
